// File: rtl/dma_pkg.sv
// Shared types and field positions for the DMA transfer-sequencing stage.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int MODE_W = 6;

  typedef enum logic [2:0] {SI, S0, SC, S1, S2, S3, S4} state_t;

  typedef enum logic [1:0] {
    XFER_VERIFY = 2'b00,
    XFER_WRITE  = 2'b01,
    XFER_READ   = 2'b10,
    XFER_RSVD   = 2'b11
  } xfer_t;

  typedef enum logic [1:0] {
    MODE_DEMAND  = 2'b00,
    MODE_SINGLE  = 2'b01,
    MODE_BLOCK   = 2'b10,
    MODE_CASCADE = 2'b11
  } mode_sel_t;

  // Bit positions inside one mode-register entry
  localparam int MODE_TYPE_LSB = 0;
  localparam int MODE_AUTOINIT = 2;
  localparam int MODE_DEC      = 3;
  localparam int MODE_SEL_LSB  = 4;

  // Bit positions inside the command register
  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

endpackage

// File: rtl/dma_timing_control_if.sv
// Bus and datapath signals of the DMA timing-control stage; the controller uses master.
interface dma_timing_control_if;
  import dma_pkg::*;

  logic [NUM_CH-1:0]        DREQ;
  logic                     HLDA;
  logic                     EOP_N_in;
  logic [7:0]               commandReg;
  logic [NUM_CH*MODE_W-1:0] modeReg;
  logic                     wcZero;
  logic                     HRQ;
  logic                     AEN;
  logic                     ADSTB;
  logic                     MEMR_N;
  logic                     MEMW_N;
  logic                     IOR_N;
  logic                     IOW_N;
  logic [NUM_CH-1:0]        DACK;
  logic                     EOP_N_out;
  logic [1:0]               activeCh;
  logic                     addrStep;
  logic                     addrDec;
  logic                     wcStep;
  logic                     tcReload;

  modport master (
    input  DREQ, HLDA, EOP_N_in, commandReg, modeReg, wcZero,
    output HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, DACK,
           EOP_N_out, activeCh, addrStep, addrDec, wcStep, tcReload
  );

  modport slave (
    output DREQ, HLDA, EOP_N_in, commandReg, modeReg, wcZero,
    input  HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, DACK,
           EOP_N_out, activeCh, addrStep, addrDec, wcStep, tcReload
  );
endinterface

// File: rtl/dma_priority_resolver.sv
// Picks one requesting channel, fixed (ch0 first) or rotating (after last serviced).
module dma_priority_resolver
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] dreq,
  input  logic              dreq_low,
  input  logic              rotate,
  input  logic [1:0]        last_ch,
  output logic [1:0]        grant,
  output logic              valid
);

  logic [NUM_CH-1:0] req;
  logic [1:0]        start;
  logic [1:0]        idx;

  assign req   = dreq_low ? ~dreq : dreq;
  assign start = rotate ? last_ch + 2'd1 : 2'd0;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // Walk from lowest priority to highest so the highest requester wins last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_timing_control.sv
// DMA transfer sequencer: arbitration, HRQ/HLDA handshake, S1-S4 strobes, step pulses.
module dma_timing_control
  import dma_pkg::*;
(
  input logic CLK,
  input logic RESET,
  dma_timing_control_if.master bus
);

  state_t            state;
  logic [1:0]        active_ch, rot_ptr, last_ch, grant;
  logic              grant_valid;
  logic [NUM_CH-1:0] dreq_act, dack_act;
  logic [MODE_W-1:0] mode_ent;
  xfer_t             xfer;
  mode_sel_t         msel;
  logic              autoinit, dec_mode, cur_req, tc, in_s4, eop_seen, keep_going;
  logic              hrq, aen, adstb, memr_n, memw_n, ior_n, iow_n;
  logic              addr_step, addr_dec, wc_step;
  logic              unused_cmd_bits;

  assign unused_cmd_bits = &{bus.commandReg[5], bus.commandReg[3], bus.commandReg[1:0]};

  assign last_ch  = rot_ptr - 2'd1;
  assign dreq_act = bus.commandReg[CMD_DREQ_LOW] ? ~bus.DREQ : bus.DREQ;
  assign cur_req  = dreq_act[active_ch];

  assign mode_ent = bus.modeReg[active_ch*MODE_W +: MODE_W];
  assign xfer     = xfer_t'(mode_ent[MODE_TYPE_LSB +: 2]);
  assign msel     = mode_sel_t'(mode_ent[MODE_SEL_LSB +: 2]);
  assign autoinit = mode_ent[MODE_AUTOINIT];
  assign dec_mode = mode_ent[MODE_DEC];

  // Terminal count is judged from the word count seen during S4 itself.
  assign in_s4      = (state == S4);
  assign tc         = bus.wcZero | eop_seen;
  assign keep_going = !bus.commandReg[CMD_DISABLE] && !tc &&
                      ((msel == MODE_BLOCK) || (msel == MODE_DEMAND && cur_req));

  dma_priority_resolver u_prio (
    .dreq     (bus.DREQ),
    .dreq_low (bus.commandReg[CMD_DREQ_LOW]),
    .rotate   (bus.commandReg[CMD_ROTATE]),
    .last_ch  (last_ch),
    .grant    (grant),
    .valid    (grant_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= SI;
      hrq       <= 1'b0;
      aen       <= 1'b0;
      adstb     <= 1'b0;
      {memr_n, memw_n, ior_n, iow_n} <= '1;
      dack_act  <= '0;
      active_ch <= '0;
      rot_ptr   <= '0;
      eop_seen  <= 1'b0;
      addr_step <= 1'b0;
      addr_dec  <= 1'b0;
      wc_step   <= 1'b0;
    end else begin
      adstb     <= 1'b0;
      addr_step <= 1'b0;
      addr_dec  <= 1'b0;
      wc_step   <= 1'b0;
      unique case (state)
        SI: if (!bus.commandReg[CMD_DISABLE] && grant_valid) begin
          active_ch <= grant;
          hrq       <= 1'b1;
          state     <= S0;
        end
        S0: if (!cur_req) begin
          hrq   <= 1'b0;
          state <= SI;
        end else if (bus.HLDA) begin
          dack_act <= NUM_CH'(1) << active_ch;
          if (msel == MODE_CASCADE) begin
            state <= SC;
          end else begin
            aen      <= 1'b1;
            adstb    <= 1'b1;
            eop_seen <= 1'b0;
            state    <= S1;
          end
        end
        SC: if (!cur_req) begin
          hrq      <= 1'b0;
          dack_act <= '0;
          rot_ptr  <= active_ch + 2'd1;
          state    <= SI;
        end
        S1, S2, S3: begin
          if (!bus.HLDA) begin
            // Bus taken back: abandon the transfer without stepping anything.
            {memr_n, memw_n, ior_n, iow_n} <= '1;
            hrq      <= 1'b0;
            aen      <= 1'b0;
            dack_act <= '0;
            state    <= SI;
          end else if (state == S1) begin
            memr_n <= (xfer != XFER_READ);
            ior_n  <= (xfer != XFER_WRITE);
            state  <= S2;
          end else if (state == S2) begin
            memw_n <= (xfer != XFER_WRITE);
            iow_n  <= (xfer != XFER_READ);
            if (!bus.EOP_N_in) eop_seen <= 1'b1;
            state  <= S3;
          end else begin
            {memr_n, memw_n, ior_n, iow_n} <= '1;
            addr_step <= 1'b1;
            wc_step   <= 1'b1;
            addr_dec  <= dec_mode;
            if (!bus.EOP_N_in) eop_seen <= 1'b1;
            state     <= S4;
          end
        end
        S4: if (keep_going) begin
          adstb    <= 1'b1;
          eop_seen <= 1'b0;
          state    <= S1;
        end else begin
          hrq      <= 1'b0;
          aen      <= 1'b0;
          dack_act <= '0;
          rot_ptr  <= active_ch + 2'd1;
          state    <= SI;
        end
        default: state <= SI;
      endcase
    end
  end

  assign bus.HRQ       = hrq;
  assign bus.AEN       = aen;
  assign bus.ADSTB     = adstb;
  assign bus.MEMR_N    = memr_n;
  assign bus.MEMW_N    = memw_n;
  assign bus.IOR_N     = ior_n;
  assign bus.IOW_N     = iow_n;
  // commandReg[7]=1 selects active-high DACK, 0 active-low (8237 sense)
  assign bus.DACK      = bus.commandReg[CMD_DACK_HIGH] ? dack_act : ~dack_act;
  assign bus.EOP_N_out = ~(in_s4 & bus.wcZero);
  assign bus.tcReload  = in_s4 & tc & autoinit;
  assign bus.activeCh  = active_ch;
  assign bus.addrStep  = addr_step;
  assign bus.addrDec   = addr_dec;
  assign bus.wcStep    = wc_step;

endmodule

// File: tb/tb_dma_timing_control.sv
// Directed bench for dma_timing_control; inputs change and outputs are sampled on negedge.
module tb_dma_timing_control;

  logic CLK = 1'b0;
  logic RESET;
  logic hlda_auto;
  int   total = 0;
  int   bad   = 0;

  dma_timing_control_if bus ();

  dma_timing_control dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  // Packed order: HRQ AEN ADSTB | MEMR_N MEMW_N IOR_N IOW_N | addrStep wcStep | EOP_N_out tcReload
  localparam logic [10:0] IDLE    = 11'b0_0_0_1111_00_1_0;
  localparam logic [10:0] V_HOLD  = 11'b1_0_0_1111_00_1_0;
  localparam logic [10:0] V_S1    = 11'b1_1_1_1111_00_1_0;
  localparam logic [10:0] V_NOSTB = 11'b1_1_0_1111_00_1_0;
  localparam logic [10:0] V_STEP  = 11'b1_1_0_1111_11_1_0;
  localparam logic [10:0] V_TC    = 11'b1_1_0_1111_11_0_1;
  localparam logic [10:0] V_RD_S2 = 11'b1_1_0_0111_00_1_0;
  localparam logic [10:0] V_RD_S3 = 11'b1_1_0_0110_00_1_0;
  localparam logic [10:0] V_WR_S2 = 11'b1_1_0_1101_00_1_0;
  localparam logic [10:0] V_WR_S3 = 11'b1_1_0_1001_00_1_0;

  function automatic logic [10:0] snap();
    return {bus.HRQ, bus.AEN, bus.ADSTB, bus.MEMR_N, bus.MEMW_N, bus.IOR_N, bus.IOW_N,
            bus.addrStep, bus.wcStep, bus.EOP_N_out, bus.tcReload};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (hlda_auto) bus.HLDA = bus.HRQ;
  endtask

  task automatic do_reset();
    RESET        = 1'b1;
    bus.DREQ     = '0;
    bus.HLDA     = 1'b0;
    bus.EOP_N_in = 1'b1;
    bus.wcZero   = 1'b0;
    hlda_auto    = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rot [5] = '{0, 1, 2, 3, 0};

    bus.commandReg = 8'h00;
    bus.modeReg    = '0;
    do_reset();
    check("rst_bus",  snap(), IDLE);
    check("rst_ch",   bus.activeCh, 0);
    check("rst_dack", bus.DACK, 4'hF);

    // Single read on ch2
    bus.modeReg[17:12] = 6'b010010;
    bus.DREQ = 4'b0100;
    tick(); check("t1_s0", snap(), V_HOLD); check("t1_ch", bus.activeCh, 2);
    tick(); check("t1_s1", snap(), V_S1);   check("t1_dack", bus.DACK, 4'b1011);
    tick(); check("t1_s2", snap(), V_RD_S2);
    tick(); check("t1_s3", snap(), V_RD_S3);
    tick(); check("t1_s4", snap(), V_STEP); check("t1_dec", bus.addrDec, 0);
    tick(); check("t1_si", snap(), IDLE);   check("t1_dack_off", bus.DACK, 4'hF);
    bus.DREQ = '0;

    // Block write on ch0, autoinit + decrement, TC on the third transfer
    do_reset();
    bus.modeReg = '0;
    bus.modeReg[5:0] = 6'b101101;
    bus.DREQ = 4'b0001;
    tick(); check("t2_s0", snap(), V_HOLD);
    for (int t = 0; t < 3; t++) begin
      tick(); check($sformatf("t2_s1_%0d", t), snap(), V_S1);
      tick(); check($sformatf("t2_s2_%0d", t), snap(), V_WR_S2);
      tick(); check($sformatf("t2_s3_%0d", t), snap(), V_WR_S3);
      if (t == 2) bus.wcZero = 1'b1;
      tick(); check($sformatf("t2_s4_%0d", t), snap(), (t == 2) ? V_TC : V_STEP);
      check($sformatf("t2_dec_%0d", t), bus.addrDec, 1);
    end
    bus.DREQ = '0;
    tick(); check("t2_si", snap(), IDLE);
    bus.wcZero = 1'b0;

    // Rotating priority with all four channels requesting, single verify
    do_reset();
    bus.commandReg = 8'h10;
    bus.modeReg    = {4{6'b010000}};
    bus.DREQ       = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick(); check($sformatf("t3_rot_%0d", k), bus.activeCh, exp_rot[k]);
      tick();
      tick(); check($sformatf("t3_vfy_%0d", k), snap(), V_NOSTB);
      tick(); tick(); tick();
    end

    // Fixed priority always grants ch0
    do_reset();
    bus.commandReg = 8'h00;
    bus.DREQ       = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick(); check($sformatf("t3_fix_%0d", k), bus.activeCh, 0);
      repeat (5) tick();
    end

    // Demand read on ch1, DREQ released during the second S4
    do_reset();
    bus.modeReg = '0;
    bus.modeReg[11:6] = 6'b000010;
    bus.DREQ = 4'b0010;
    tick();
    for (int t = 0; t < 2; t++) begin
      tick(); check($sformatf("t4_s1_%0d", t), snap(), V_S1);
      check($sformatf("t4_dack_%0d", t), bus.DACK, 4'b1101);
      tick(); check($sformatf("t4_s2_%0d", t), snap(), V_RD_S2);
      tick();
      tick(); check($sformatf("t4_s4_%0d", t), snap(), V_STEP);
      if (t == 1) bus.DREQ = '0;
    end
    tick(); check("t4_si",   snap(), IDLE);
    tick(); check("t4_idle", snap(), IDLE);

    // Same demand channel ended by external EOP in S2
    do_reset();
    bus.DREQ = 4'b0010;
    tick(); tick(); tick();
    bus.EOP_N_in = 1'b0;
    tick();
    bus.EOP_N_in = 1'b1;
    tick(); check("t4e_s4", snap(), V_STEP);
    tick(); check("t4e_si", snap(), IDLE);
    bus.DREQ = '0;
    tick(); check("t4e_idle", snap(), IDLE);

    // Cascade on ch3 with active-high DACK
    do_reset();
    bus.commandReg = 8'h80;
    bus.modeReg = '0;
    bus.modeReg[23:18] = 6'b110000;
    bus.DREQ = 4'b1000;
    tick(); check("t5_s0",   snap(), V_HOLD); check("t5_s0_dack", bus.DACK, 4'b0000);
    tick(); check("t5_sc_a", snap(), V_HOLD); check("t5_sc_dack", bus.DACK, 4'b1000);
    tick(); check("t5_sc_b", snap(), V_HOLD);
    bus.DREQ = '0;
    tick(); check("t5_si",   snap(), IDLE);   check("t5_si_dack", bus.DACK, 4'b0000);

    // HLDA withdrawn during S2 of a verify transfer on ch3
    do_reset();
    bus.commandReg = 8'h00;
    bus.modeReg = '0;
    bus.modeReg[23:18] = 6'b010000;
    bus.DREQ = 4'b1000;
    tick(); tick();
    tick(); check("t5h_s2", snap(), V_NOSTB);
    hlda_auto = 1'b0;
    bus.HLDA  = 1'b0;
    tick(); check("t5h_si", snap(), IDLE); check("t5h_dack", bus.DACK, 4'hF);
    bus.DREQ = '0;
    tick(); check("t5h_idle", snap(), IDLE);

    // Reset during S3 of a block write on ch2
    do_reset();
    bus.modeReg = '0;
    bus.modeReg[17:12] = 6'b100001;
    bus.DREQ = 4'b0100;
    tick(); tick(); tick();
    tick(); check("t6_s3", snap(), V_WR_S3);
    RESET = 1'b1;
    tick(); check("t6_rst", snap(), IDLE);
    check("t6_ch",   bus.activeCh, 0);
    check("t6_dack", bus.DACK, 4'hF);
    RESET = 1'b0;
    bus.DREQ = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_timing_control.md
Name: dma_timing_control

Overview:
- Transfer-sequencing stage directly downstream of the DMA register datapath. Consumes the command register, the four per-channel mode registers and the word-count status.
- Arbitrates the four DREQ inputs, runs the bus-acquisition handshake (HRQ/HLDA) and sequences each transfer through states S1–S4, driving the memory and I/O strobes.
- Pulses update requests back to the datapath so it can step the current address and word count.

Parameters:
- NUM_CH, 4, number of DMA channels (fixed 4; channel index 2 bits)
- MODE_W, 6, width of one mode-register entry

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- DREQ  input  4  channel requests; active level set by commandReg[6] (0=high, 1=low)
- HLDA  input  1  hold acknowledge from CPU
- EOP_N_in  input  1  external end-of-process, active low
- commandReg  input  8  [2]=controller disable, [4]=rotating priority, [6]=DREQ sense, [7]=DACK sense
- modeReg  input  24  4×6 entries; ch n at [6n+5:6n]: [1:0]=type (00 verify, 01 write, 10 read), [2]=autoinit, [3]=addr decrement, [5:4]=mode (00 demand, 01 single, 10 block, 11 cascade)
- wcZero  input  1  current word count of active channel is 0 before this transfer
- HRQ  output  1  hold request
- AEN  output  1  address enable
- ADSTB  output  1  address strobe
- MEMR_N, MEMW_N, IOR_N, IOW_N  output  1 each  bus strobes, active low
- DACK  output  4  channel acknowledges; polarity per commandReg[7]
- EOP_N_out  output  1  terminal-count indication, active low
- activeCh  output  2  channel being serviced
- addrStep  output  1  one-cycle pulse: step current address (+1, or −1 if mode[3])
- addrDec  output  1  valid with addrStep
- wcStep  output  1  one-cycle pulse: decrement current word count
- tcReload  output  1  one-cycle pulse: reload current registers from base registers (autoinit at TC)

Behaviour:
- Reset: state SI. HRQ, AEN, ADSTB, addrStep, wcStep and tcReload are 0. All strobes and EOP_N_out are 1. DACK is inactive per its polarity. activeCh=0. Priority rotation pointer=0.
- SI: if commandReg[2]=0 and any DREQ is active:
  - Latch the winner into activeCh.
  - Fixed priority: ch0 highest. Rotating priority: the channel after the last serviced one is highest.
  - Assert HRQ next cycle and go to S0.
- S0: HRQ held. Wait for HLDA=1.
  - Cascade mode: go to SC.
  - Otherwise: go to S1.
  - If the latched DREQ drops before HLDA: return to SI and drop HRQ.
- SC: DACK[activeCh] active, no strobes, AEN=0. Stay until DREQ[activeCh] deasserts, then go to SI and drop HRQ.
- S1: AEN=1, ADSTB=1 for this cycle only. DACK[activeCh] asserted from S1 through S4.
- S2: read strobe asserted (IOR_N for write type, MEMR_N for read type). Held through S3.
- S3: write strobe asserted (MEMW_N for write type, IOW_N for read type). Verify type: no strobes in S2/S3.
- S4: all strobes released.
  - addrStep and wcStep pulse.
  - TC = wcZero sampled in S4. On TC: EOP_N_out=0 for this cycle. If autoinit, tcReload pulses.
- EOP_N_in=0 sampled in S2 or S3 is latched. It acts as TC at S4, but without the EOP_N_out pulse.
- Exit from S4:
  - Single mode: go to SI.
  - Block mode: go to S1 unless TC/EOP.
  - Demand mode: go to S1 if DREQ[activeCh] is still active and there is no TC/EOP; else SI.
  - Leaving to SI drops HRQ and AEN the next cycle and updates the rotation pointer.
- Latency: DREQ to HRQ is 1 cycle. HLDA to ADSTB is 1 cycle. One non-cascade transfer is 4 cycles (S1–S4). Back-to-back block transfers are 4 cycles each.
- HLDA deasserted in S1–S3: go to SI next cycle, release all strobes, no addrStep/wcStep.
- commandReg[2] set mid-transfer: the current transfer completes, then go to SI.
- Reset mid-transfer: reset values on the next edge, no step pulses.
- Simultaneous DREQs: exactly one channel is granted, per the priority rule.

Decomposition:
- Shared package dma_pkg holds:
  - state enum {SI, S0, SC, S1, S2, S3, S4}
  - transfer-type and mode-select enums
  - mode-field bit-index constants
  - command-bit constants
- Sub-module dma_priority_resolver: DREQ vector, polarity, rotate enable and last-serviced channel in; grant index and valid out. Combinational, with its rotation pointer register inside the parent.

Test Plan:
- Single mode, read, ch2: DREQ=4'b0100, HLDA tied to HRQ after 1 cycle → activeCh=2; ADSTB pulses in S1; MEMR_N low for 2 cycles, then IOW_N low for 1 cycle; addrStep/wcStep pulse in S4; HRQ drops 1 cycle later.
- Block mode, write, ch0, wcZero asserted on the 3rd transfer → 3×4-cycle transfers; EOP_N_out low in the 3rd S4; return to SI; with autoinit=1, tcReload pulses once.
- DREQ=4'b1111 with rotating priority → grants 0,1,2,3,0 across successive single transfers; with fixed priority, always 0.
- Demand mode, ch1: DREQ deasserted after the 2nd S4 → exactly 2 transfers; EOP_N_in pulled low in S2 of the 1st transfer instead → 1 transfer and no EOP_N_out pulse.
- Cascade ch3: DACK[3] active and all strobes high until DREQ[3] drops, then HRQ drops; HLDA removed during S2 of a verify transfer → SI next cycle, no step pulses.
- RESET asserted in S3 → next cycle all outputs at reset values.
